iob_cpu_native_bridge: RTL and testbench

Parametrised bridge between a PicoRV32-style native CPU memory port and `N_SLAVES` IOb-native request/response buses. It replaces a fixed instruction/data split with address-based routing and a boot-time instruction remap. It adds a registered request path, write-acknowledge generation, and a bus timeout with error response. It sits between the CPU core and the system interconnect.

---
 rtl/iob_cpu_native_bridge_pkg.sv | 13 +
 rtl/iob_cpu_bridge_tmr.sv | 38 +++
 rtl/iob_cpu_native_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_iob_cpu_native_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cpu_native_bridge_pkg.sv
// Shared types and defaults for the CPU native-port to IOb-native bridge.
package iob_cpu_native_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWaitR = 2'd2,
        StDone  = 2'd3
    } bridge_state_e;

    localparam logic [31:0] ErrDataDefault = 32'hDEADBEEF;

endpackage

// File: rtl/iob_cpu_bridge_tmr.sv
// Access timeout counter: clears on request start, counts active cycles, flags the terminal count.
module iob_cpu_bridge_tmr #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] Term = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturate at the terminal count so an expired budget stays expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Term)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else if (cke_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (TIMEOUT != 0) && en_i && (cnt_q == Term);

endmodule

// File: rtl/iob_cpu_native_bridge.sv
// Routes a PicoRV32-style native memory request to one of N IOb-native buses by address,
// with boot-time instruction remap, write acknowledge and timeout error response.
module iob_cpu_native_bridge
    import iob_cpu_native_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       N_SLAVES = 2,
    parameter int unsigned       BOOT_SEL = 0,
    parameter int unsigned       TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ErrDataDefault)
) (
    input  logic                           clk_i,
    input  logic                           arst_n_i,
    input  logic                           cke_i,
    input  logic                           boot_i,
    input  logic                           cpu_valid_i,
    input  logic                           cpu_instr_i,
    input  logic [ADDR_W-1:0]              cpu_addr_i,
    input  logic [DATA_W-1:0]              cpu_wdata_i,
    input  logic [DATA_W/8-1:0]            cpu_wstrb_i,
    output logic                           cpu_ready_o,
    output logic [DATA_W-1:0]              cpu_rdata_o,
    output logic                           err_o,
    output logic                           err_sticky_o,
    output logic [N_SLAVES-1:0]            iob_avalid_o,
    output logic [N_SLAVES*ADDR_W-1:0]     iob_addr_o,
    output logic [N_SLAVES*DATA_W-1:0]     iob_wdata_o,
    output logic [N_SLAVES*DATA_W/8-1:0]   iob_wstrb_o,
    input  logic [N_SLAVES*DATA_W-1:0]     iob_rdata_i,
    input  logic [N_SLAVES-1:0]            iob_rvalid_i,
    input  logic [N_SLAVES-1:0]            iob_ready_i
);

    localparam int unsigned SEL_W  = $clog2(N_SLAVES);
    localparam int unsigned STRB_W = DATA_W / 8;

    bridge_state_e                state_q, state_d;
    logic [SEL_W-1:0]             sel_q, sel_d, sel_in;
    logic                         sel_in_ok;
    logic [N_SLAVES-1:0]          avalid_q, avalid_d;
    logic [N_SLAVES*ADDR_W-1:0]   addr_q, addr_d;
    logic [N_SLAVES*DATA_W-1:0]   wdata_q, wdata_d;
    logic [N_SLAVES*STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                         ready_q, ready_d;
    logic                         err_q, err_d;
    logic                         sticky_q, sticky_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;
    logic                         tmr_clr, tmr_en, tmr_done;
    logic                         to_err;
    logic                         sel_ready, sel_rvalid, sel_write;
    logic [DATA_W-1:0]            sel_rdata;

    always_comb begin
        sel_in = cpu_addr_i[ADDR_W-1 -: SEL_W];
        if (cpu_instr_i && boot_i) begin
            sel_in = SEL_W'(BOOT_SEL);
        end
    end

    assign sel_in_ok = 32'(sel_in) < N_SLAVES;

    // Only the captured slave's handshake lines are ever looked at.
    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_write  = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready  = iob_ready_i[i];
                sel_rvalid = iob_rvalid_i[i];
                sel_write  = |wstrb_q[i*STRB_W +: STRB_W];
                sel_rdata  = iob_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmr_en = (state_q == StReq) || (state_q == StWaitR);

    iob_cpu_bridge_tmr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .done_o   (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        avalid_d = avalid_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        rdata_d  = rdata_q;
        tmr_clr  = 1'b0;
        to_err   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_valid_i) begin
                    sel_d    = sel_in;
                    avalid_d = '0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    if (sel_in_ok) begin
                        for (int i = 0; i < int'(N_SLAVES); i++) begin
                            if (sel_in == SEL_W'(i)) begin
                                avalid_d[i]                   = 1'b1;
                                addr_d[i*ADDR_W +: ADDR_W]    = cpu_addr_i;
                                wdata_d[i*DATA_W +: DATA_W]   = cpu_wdata_i;
                                wstrb_d[i*STRB_W +: STRB_W]   = cpu_wstrb_i;
                            end
                        end
                        tmr_clr = 1'b1;
                        state_d = StReq;
                    end else begin
                        to_err = 1'b1;
                    end
                end
            end
            StReq: begin
                // A response coinciding with expiry takes priority over the error.
                if (sel_ready) begin
                    avalid_d = '0;
                    if (sel_write) begin
                        state_d = StDone;
                        ready_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = StWaitR;
                    end
                end else if (tmr_done) begin
                    to_err = 1'b1;
                end
            end
            StWaitR: begin
                if (sel_rvalid) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    rdata_d = sel_rdata;
                end else if (tmr_done) begin
                    to_err = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (to_err) begin
            state_d  = StDone;
            avalid_d = '0;
            ready_d  = 1'b1;
            err_d    = 1'b1;
            sticky_d = 1'b1;
            rdata_d  = ERR_DATA;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            avalid_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            avalid_q <= avalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cpu_ready_o  = ready_q;
    assign cpu_rdata_o  = rdata_q;
    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;
    assign iob_avalid_o = avalid_q;
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_iob_cpu_native_bridge.sv
// Directed bench: a 2-slave bridge for routing/timing and a 3-slave bridge for out-of-range select.
module tb_iob_cpu_native_bridge;

    logic        clk, arst_n, cke, boot, valid, instr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        cpu_ready, err, sticky;
    logic [31:0] cpu_rdata;
    logic [1:0]  avalid, rvalid, ready;
    logic [63:0] iob_addr, iob_wdata, iob_rdata;
    logic [7:0]  iob_wstrb;

    logic        valid3;
    logic [31:0] addr3;
    logic        cpu_ready3, err3, sticky3;
    logic [31:0] cpu_rdata3;
    logic [2:0]  avalid3, rvalid3, ready3;
    logic [95:0] iob_addr3, iob_wdata3, iob_rdata3;
    logic [11:0] iob_wstrb3;

    int total = 0;
    int bad   = 0;

    iob_cpu_native_bridge #(
        .N_SLAVES (2),
        .BOOT_SEL (0),
        .TIMEOUT  (8)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cke_i        (cke),
        .boot_i       (boot),
        .cpu_valid_i  (valid),
        .cpu_instr_i  (instr),
        .cpu_addr_i   (addr),
        .cpu_wdata_i  (wdata),
        .cpu_wstrb_i  (wstrb),
        .cpu_ready_o  (cpu_ready),
        .cpu_rdata_o  (cpu_rdata),
        .err_o        (err),
        .err_sticky_o (sticky),
        .iob_avalid_o (avalid),
        .iob_addr_o   (iob_addr),
        .iob_wdata_o  (iob_wdata),
        .iob_wstrb_o  (iob_wstrb),
        .iob_rdata_i  (iob_rdata),
        .iob_rvalid_i (rvalid),
        .iob_ready_i  (ready)
    );

    iob_cpu_native_bridge #(
        .N_SLAVES (3),
        .TIMEOUT  (8)
    ) dut3 (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cke_i        (cke),
        .boot_i       (boot),
        .cpu_valid_i  (valid3),
        .cpu_instr_i  (instr),
        .cpu_addr_i   (addr3),
        .cpu_wdata_i  (wdata),
        .cpu_wstrb_i  (wstrb),
        .cpu_ready_o  (cpu_ready3),
        .cpu_rdata_o  (cpu_rdata3),
        .err_o        (err3),
        .err_sticky_o (sticky3),
        .iob_avalid_o (avalid3),
        .iob_addr_o   (iob_addr3),
        .iob_wdata_o  (iob_wdata3),
        .iob_wstrb_o  (iob_wstrb3),
        .iob_rdata_i  (iob_rdata3),
        .iob_rvalid_i (rvalid3),
        .iob_ready_i  (ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next cycle: inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (avalid !== 2'b00) begin bad++; $display("FAIL rst_avalid got=%h want=0", avalid); end
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cpu_ready); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", cpu_rdata); end
        total++; if ({err, sticky} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=00", {err, sticky}); end
        total++; if (iob_addr !== 64'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", iob_addr); end
        step(); step();
        arst_n = 1'b1;
    endtask

    task automatic test_write();
        step();
        valid = 1'b1; addr = 32'h0000_0010; wdata = 32'h1234_5678; wstrb = 4'hF;
        step();
        total++; if (avalid !== 2'b01) begin bad++; $display("FAIL wr_avalid got=%b want=01", avalid); end
        total++; if (iob_addr !== 64'h0000_0000_0000_0010) begin bad++; $display("FAIL wr_addr got=%h want=10", iob_addr); end
        total++; if (iob_wdata !== 64'h0000_0000_1234_5678) begin bad++; $display("FAIL wr_wdata got=%h want=12345678", iob_wdata); end
        total++; if (iob_wstrb !== 8'h0F) begin bad++; $display("FAIL wr_wstrb got=%h want=0f", iob_wstrb); end
        ready = 2'b01;
        step();
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", cpu_ready); end
        total++; if (avalid !== 2'b00) begin bad++; $display("FAIL wr_avalid_drop got=%b want=00", avalid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
        ready = 2'b00; valid = 1'b0;
        step();
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_pulse got=%b want=0", cpu_ready); end
    endtask

    task automatic test_read();
        step();
        valid = 1'b1; addr = 32'h8000_0004; wstrb = 4'h0;
        step();
        total++; if (avalid !== 2'b10) begin bad++; $display("FAIL rd_avalid got=%b want=10", avalid); end
        ready = 2'b10;
        step();
        ready = 2'b00;
        total++; if (avalid !== 2'b00 || cpu_ready !== 1'b0) begin bad++; $display("FAIL rd_accept got=%b/%b want=00/0", avalid, cpu_ready); end
        step();
        rvalid = 2'b01; iob_rdata = {32'h0, 32'h1111_1111};
        step();
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rd_stray got=%b want=0", cpu_ready); end
        rvalid = 2'b10; iob_rdata = {32'hCAFE_F00D, 32'h1111_1111};
        step();
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got=%b want=1", cpu_ready); end
        total++; if (cpu_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_data got=%h want=cafef00d", cpu_rdata); end
        rvalid = 2'b00; valid = 1'b0;
        step();
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rd_ready_pulse got=%b want=0", cpu_ready); end
    endtask

    task automatic test_boot();
        step();
        boot = 1'b1; instr = 1'b1; valid = 1'b1; addr = 32'h8000_0000; wstrb = 4'h0;
        step();
        total++; if (avalid !== 2'b01) begin bad++; $display("FAIL boot_avalid got=%b want=01", avalid); end
        total++; if (iob_addr !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL boot_addr got=%h want=80000000", iob_addr); end
        ready = 2'b01;
        step();
        ready = 2'b00; rvalid = 2'b01; iob_rdata = {32'h0, 32'h0B00_7000};
        step();
        total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h0B00_7000) begin bad++; $display("FAIL boot_rd got=%b/%h want=1/0b007000", cpu_ready, cpu_rdata); end
        rvalid = 2'b00; valid = 1'b0;
        step();
        boot = 1'b0; valid = 1'b1;
        step();
        total++; if (avalid !== 2'b10) begin bad++; $display("FAIL noboot_avalid got=%b want=10", avalid); end
        ready = 2'b10;
        step();
        ready = 2'b00; rvalid = 2'b10; iob_rdata = {32'h0000_1234, 32'h0};
        step();
        total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h0000_1234) begin bad++; $display("FAIL noboot_rd got=%b/%h want=1/00001234", cpu_ready, cpu_rdata); end
        rvalid = 2'b00; valid = 1'b0; instr = 1'b0;
    endtask

    task automatic test_cke();
        step();
        valid = 1'b1; addr = 32'h0000_0004; wdata = 32'h0000_00A5; wstrb = 4'b0011;
        step();
        total++; if (avalid !== 2'b01) begin bad++; $display("FAIL cke_avalid got=%b want=01", avalid); end
        cke = 1'b0; ready = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (avalid !== 2'b01 || cpu_ready !== 1'b0) begin bad++; $display("FAIL cke_hold got=%b/%b want=01/0", avalid, cpu_ready); end
        end
        cke = 1'b1;
        step();
        total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h0) begin bad++; $display("FAIL cke_wr got=%b/%h want=1/0", cpu_ready, cpu_rdata); end
        total++; if (iob_wstrb !== 8'h03) begin bad++; $display("FAIL cke_wstrb got=%h want=03", iob_wstrb); end
        ready = 2'b00; valid = 1'b0;
    endtask

    task automatic test_simultaneous();
        step();
        valid = 1'b1; addr = 32'h0000_0020; wdata = 32'h5555_0000; wstrb = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 8) ready = 2'b01;
        end
        step();
        total++; if (cpu_ready !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL simul_resp got=%b/%b want=1/0", cpu_ready, err); end
        total++; if (sticky !== 1'b0) begin bad++; $display("FAIL simul_sticky got=%b want=0", sticky); end
        ready = 2'b00; valid = 1'b0;
    endtask

    task automatic test_timeout();
        step();
        valid = 1'b1; addr = 32'h8000_0008; wstrb = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++; if (avalid !== 2'b10 || cpu_ready !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b want=10/0", k, avalid, cpu_ready); end
        end
        step();
        total++; if (cpu_ready !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL to_resp got=%b/%b want=1/1", cpu_ready, err); end
        total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_data got=%h want=deadbeef", cpu_rdata); end
        total++; if (avalid !== 2'b00 || sticky !== 1'b1) begin bad++; $display("FAIL to_state got=%b/%b want=00/1", avalid, sticky); end
        valid = 1'b0;
        step();
        total++; if (err !== 1'b0 || sticky !== 1'b1) begin bad++; $display("FAIL to_after got=%b/%b want=0/1", err, sticky); end
        rvalid = 2'b10; iob_rdata = {32'h7777_7777, 32'h0};
        step();
        total++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_late got=%b/%h want=0/deadbeef", cpu_ready, cpu_rdata); end
        rvalid = 2'b00;
    endtask

    task automatic test_out_of_range();
        step();
        valid3 = 1'b1; addr3 = 32'hC000_0000; wstrb = 4'h0;
        step();
        total++; if (cpu_ready3 !== 1'b1 || err3 !== 1'b1) begin bad++; $display("FAIL oob_resp got=%b/%b want=1/1", cpu_ready3, err3); end
        total++; if (avalid3 !== 3'b000) begin bad++; $display("FAIL oob_avalid got=%b want=000", avalid3); end
        total++; if (cpu_rdata3 !== 32'hDEAD_BEEF || sticky3 !== 1'b1) begin bad++; $display("FAIL oob_data got=%h/%b want=deadbeef/1", cpu_rdata3, sticky3); end
        valid3 = 1'b0;
        step();
        total++; if (cpu_ready3 !== 1'b0 || avalid3 !== 3'b000) begin bad++; $display("FAIL oob_after got=%b/%b want=0/000", cpu_ready3, avalid3); end
    endtask

    task automatic test_reset_mid();
        step();
        valid = 1'b1; addr = 32'h8000_0010; wstrb = 4'h0;
        step();
        ready = 2'b10;
        step();
        ready = 2'b00;
        arst_n = 1'b0; valid = 1'b0;
        #1;
        total++; if (avalid !== 2'b00 || cpu_ready !== 1'b0) begin bad++; $display("FAIL mrst_out got=%b/%b want=00/0", avalid, cpu_ready); end
        total++; if (cpu_rdata !== 32'h0 || {err, sticky} !== 2'b00) begin bad++; $display("FAIL mrst_data got=%h/%b want=0/00", cpu_rdata, {err, sticky}); end
        total++; if (iob_addr !== 64'h0) begin bad++; $display("FAIL mrst_addr got=%h want=0", iob_addr); end
        rvalid = 2'b10; iob_rdata = {32'h9999_9999, 32'h0};
        step(); step();
        rvalid = 2'b00; arst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL mrst_spur got=%b want=0", cpu_ready); end
        end
        valid = 1'b1; addr = 32'h8000_0014;
        step();
        total++; if (avalid !== 2'b10) begin bad++; $display("FAIL mrst_avalid got=%b want=10", avalid); end
        ready = 2'b10;
        step();
        ready = 2'b00; rvalid = 2'b10; iob_rdata = {32'h5A5A_A5A5, 32'h0};
        step();
        total++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h5A5A_A5A5 || err !== 1'b0) begin bad++; $display("FAIL mrst_rd got=%b/%h/%b want=1/5a5aa5a5/0", cpu_ready, cpu_rdata, err); end
        rvalid = 2'b00; valid = 1'b0;
        step();
    endtask

    initial begin
        arst_n = 1'b0; cke = 1'b1; boot = 1'b0; valid = 1'b0; instr = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        iob_rdata = '0; rvalid = '0; ready = '0;
        valid3 = 1'b0; addr3 = '0; iob_rdata3 = '0; rvalid3 = '0; ready3 = '0;
        test_reset();
        test_write();
        test_read();
        test_boot();
        test_cke();
        test_simultaneous();
        test_timeout();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
